// File: rtl/xcel_mem_arbiter_if.sv
// Adapter-side bus between the memory arbiter and the AXI adapter.
// master: arbiter side (drives requests); slave: adapter side.
interface xcel_mem_arbiter_if #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
);
  logic                  xcel_read_request_valid;
  logic                  xcel_read_request_ready;
  logic [AXI_AWIDTH-1:0] xcel_read_addr;
  logic [31:0]           xcel_read_len;
  logic [2:0]            xcel_read_size;
  logic [1:0]            xcel_read_burst;
  logic [AXI_DWIDTH-1:0] xcel_read_data;
  logic                  xcel_read_data_valid;
  logic                  xcel_read_data_ready;

  logic                  xcel_write_request_valid;
  logic                  xcel_write_request_ready;
  logic [AXI_AWIDTH-1:0] xcel_write_addr;
  logic [31:0]           xcel_write_len;
  logic [2:0]            xcel_write_size;
  logic [1:0]            xcel_write_burst;
  logic [AXI_DWIDTH-1:0] xcel_write_data;
  logic                  xcel_write_data_valid;
  logic                  xcel_write_data_ready;

  modport master (
    output xcel_read_request_valid, xcel_read_addr, xcel_read_len,
           xcel_read_size, xcel_read_burst, xcel_read_data_ready,
    input  xcel_read_request_ready, xcel_read_data, xcel_read_data_valid,
    output xcel_write_request_valid, xcel_write_addr, xcel_write_len,
           xcel_write_size, xcel_write_burst, xcel_write_data,
           xcel_write_data_valid,
    input  xcel_write_request_ready, xcel_write_data_ready
  );

  modport slave (
    input  xcel_read_request_valid, xcel_read_addr, xcel_read_len,
           xcel_read_size, xcel_read_burst, xcel_read_data_ready,
    output xcel_read_request_ready, xcel_read_data, xcel_read_data_valid,
    input  xcel_write_request_valid, xcel_write_addr, xcel_write_len,
           xcel_write_size, xcel_write_burst, xcel_write_data,
           xcel_write_data_valid,
    output xcel_write_request_ready, xcel_write_data_ready
  );
endinterface

// File: rtl/xcel_mem_arbiter.sv
// Round-robin scheduler of four single-beat memory clients onto one
// adapter read/write port pair; one transaction in flight at a time.
//
// state   | meaning
// IDLE    | arbitrate, accept one client request
// RD_REQ  | read address offered to adapter
// RD_DATA | waiting for the read data beat
// WR_REQ  | write address offered to adapter
// WR_DATA | write data beat offered to adapter
// RESP    | one-cycle completion pulse to the owning client
module xcel_mem_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int DWIDTH     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ifm_ddr_addr,
  input  logic [31:0]  wt_ddr_addr,
  input  logic [31:0]  ofm_ddr_addr,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [127:0] req_addr,
  input  logic [31:0]  wr_data,
  output logic [3:0]   resp_valid,
  output logic [31:0]  resp_data,
  xcel_mem_arbiter_if.master axi
);

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            last_q, id_q;
  logic [1:0]            winner, cand;
  logic                  grant, accept;
  logic [31:0]           win_off, win_addr;
  logic [AXI_AWIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, resp_data_q;
  logic [DWIDTH-1:0]     rd_byte;

  // Round-robin scan starting one past the last winner.
  always_comb begin
    grant  = 1'b0;
    winner = last_q;
    cand   = last_q;
    for (int k = 1; k < 5; k++) begin
      cand = last_q + 2'(k);
      if (!grant && req_valid[cand]) begin
        grant  = 1'b1;
        winner = cand;
      end
    end
  end

  // DDR byte address of the current winner; OFM offsets are word indices.
  always_comb begin
    win_off = req_addr[32*winner +: 32];
    case (winner)
      2'd0:    win_addr = ifm_ddr_addr + win_off;
      2'd1:    win_addr = wt_ddr_addr + win_off;
      default: win_addr = ofm_ddr_addr + (win_off << 2);
    endcase
  end

  // Reset is gated in so no acceptance strobe escapes during reset.
  assign accept    = (state_q == IDLE) && !rst && grant;
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;

  // Next-state logic; adapter readys only steer transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (winner == 2'd3) ? WR_REQ : RD_REQ;
      RD_REQ:  if (axi.xcel_read_request_ready) state_d = RD_DATA;
      RD_DATA: if (axi.xcel_read_data_valid) state_d = RESP;
      WR_REQ:  if (axi.xcel_write_request_ready) state_d = WR_DATA;
      WR_DATA: if (axi.xcel_write_data_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign rd_byte = axi.xcel_read_data[{addr_q[1:0], 3'b000} +: DWIDTH];

  // Transaction context captured at acceptance, read result at data fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 2'd3;
      id_q        <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        last_q  <= winner;
        id_q    <= winner;
        addr_q  <= AXI_AWIDTH'(win_addr);
        wdata_q <= wr_data;
      end
      if (state_q == RD_DATA && axi.xcel_read_data_valid)
        resp_data_q <= (id_q == 2'd2) ? axi.xcel_read_data
                                      : {{(32-DWIDTH){1'b0}}, rd_byte};
    end
  end

  assign resp_valid = (state_q == RESP) ? (4'b0001 << id_q) : 4'b0000;
  assign resp_data  = resp_data_q;

  assign axi.xcel_read_request_valid  = (state_q == RD_REQ);
  assign axi.xcel_read_data_ready     = (state_q == RD_DATA);
  assign axi.xcel_read_addr           = addr_q;
  assign axi.xcel_read_len            = 32'd0;
  assign axi.xcel_read_size           = (id_q == 2'd2) ? 3'd2 : 3'd0;
  assign axi.xcel_read_burst          = BURST_INCR;

  assign axi.xcel_write_request_valid = (state_q == WR_REQ);
  assign axi.xcel_write_data_valid    = (state_q == WR_DATA);
  assign axi.xcel_write_addr          = addr_q;
  assign axi.xcel_write_len           = 32'd0;
  assign axi.xcel_write_size          = 3'd2;
  assign axi.xcel_write_burst         = BURST_INCR;
  assign axi.xcel_write_data          = wdata_q;

endmodule
